// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared FSM state type and 7-segment encodings for seg7_count_display
package seg7_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} bcd_state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low cathodes ordered {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;

   function automatic logic [6:0] nibble_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-add-3 binary to 4-digit BCD converter
module bin2bcd_seq
   import seg7_pkg::*;
#(
   parameter int CNT_W = 6
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] bin,
   output logic             busy,
   output logic             load,
   output logic             done,
   output logic [15:0]      bcd
);

   localparam int SR_W = 16 + CNT_W;
   localparam int IT_W = $clog2(CNT_W + 1);

   bcd_state_t      state;
   logic [SR_W-1:0] sr;
   logic [SR_W-1:0] sr_adj;
   logic [IT_W-1:0] iter;

   always_comb begin
      sr_adj = sr;
      for (int k = 0; k < 4; k++) begin
         if (sr[CNT_W + 4*k +: 4] >= 4'd5)
            sr_adj[CNT_W + 4*k +: 4] = sr[CNT_W + 4*k +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         sr    <= '0;
         iter  <= '0;
         bcd   <= '0;
      end else begin
         case (state)
            IDLE: if (start) state <= LOAD;
            LOAD: begin
               sr    <= {16'h0, bin};
               iter  <= '0;
               state <= SHIFT;
            end
            SHIFT: begin
               sr <= {sr_adj[SR_W-2:0], 1'b0};
               if (int'(iter) == CNT_W - 1)
                  state <= DONE;
               else
                  iter <= iter + IT_W'(1);
            end
            DONE: begin
               bcd   <= sr[SR_W-1 -: 16];
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign load = (state == LOAD);
   assign done = (state == DONE);

endmodule

// File: rtl/seg7_count_display.sv
// rtl/seg7_count_display.sv - shows the binary counter value in decimal on a 4-digit
// common-anode display with leading-zero blanking and an anti-ghosting guard
module seg7_count_display
   import seg7_pkg::*;
#(
   parameter int CLK_HZ    = 100_000_000,
   parameter int DIGIT_HZ  = 1000,
   parameter int GUARD_CYC = 2000,
   parameter int CNT_W     = 6
)
(
   input  logic             clk_100MHz,
   input  logic             rst,
   input  logic [CNT_W-1:0] cnt,
   output logic [6:0]       seg,
   output logic             dp,
   output logic [3:0]       an
);

   localparam int SLOT_CYC = CLK_HZ / DIGIT_HZ;
   localparam int SLOT_W   = $clog2(SLOT_CYC);

   logic [SLOT_W-1:0] slot_cnt;
   logic [1:0]        digit_idx;
   logic [CNT_W-1:0]  last_bin;
   logic              disp_valid;
   logic [15:0]       disp_bcd;
   logic              conv_start;
   logic              conv_busy;
   logic              conv_load;
   logic              conv_done;
   logic [3:0]        nib;
   logic              lz_blank;

   assign conv_start = !conv_busy && (!disp_valid || cnt != last_bin);

   bin2bcd_seq #(.CNT_W(CNT_W)) u_bcd (
      .clk   (clk_100MHz),
      .rst   (rst),
      .start (conv_start),
      .bin   (cnt),
      .busy  (conv_busy),
      .load  (conv_load),
      .done  (conv_done),
      .bcd   (disp_bcd)
   );

   // A digit is blank when it and every more significant digit are zero
   always_comb begin
      nib = disp_bcd[{digit_idx, 2'b00} +: 4];
      case (digit_idx)
         2'd1:    lz_blank = (disp_bcd[15:4] == '0);
         2'd2:    lz_blank = (disp_bcd[15:8] == '0);
         2'd3:    lz_blank = (disp_bcd[15:12] == '0);
         default: lz_blank = 1'b0;
      endcase
   end

   always_ff @(posedge clk_100MHz or negedge rst) begin
      if (!rst) begin
         slot_cnt   <= '0;
         digit_idx  <= '0;
         last_bin   <= '0;
         disp_valid <= 1'b0;
         an         <= 4'b1111;
         seg        <= SEG_BLANK;
      end else begin
         if (int'(slot_cnt) == SLOT_CYC - 1) begin
            slot_cnt  <= '0;
            digit_idx <= digit_idx + 2'd1;
         end else begin
            slot_cnt <= slot_cnt + SLOT_W'(1);
         end
         if (conv_load) last_bin <= cnt;
         if (conv_done) disp_valid <= 1'b1;
         if (int'(slot_cnt) < GUARD_CYC || !disp_valid || lz_blank) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
         end else begin
            an  <= ~(4'b0001 << digit_idx);
            seg <= nibble_to_seg(nib);
         end
      end
   end

   assign dp = 1'b1;

endmodule

// File: doc/seg7_count_display.md
Name: seg7_count_display

Overview:
- Downstream consumer of the 6-bit LED counter on the Basys 3 board.
- Takes the counter's binary value and shows it in decimal on the board's 4-digit common-anode 7-segment display.
- Converts binary to BCD sequentially with a shift-add-3 FSM, then time-multiplexes the digits with leading-zero blanking and an anti-ghosting guard.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency.
- DIGIT_HZ, 1000, per-digit-slot rate. Slot length SLOT_CYC = CLK_HZ/DIGIT_HZ cycles.
- GUARD_CYC, 2000, cycles at the start of each slot with all anodes off. Must be < SLOT_CYC.
- CNT_W, 6, width of the binary input. Legal range 1..13 (max 8191 fits 4 digits).

Ports:
- clk_100MHz  in  1  system clock.
- rst  in  1  reset. Asynchronous, active-low.
- cnt  in  CNT_W  binary value from the counter. Synchronous to clk_100MHz.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low (seg[0]=CA).
- dp  out  1  decimal point, active-low. Constant 1 (off).
- an  out  4  anodes, active-low one-hot; an[0] is the rightmost digit.

Behaviour:
- Reset (rst=0, async): an=4'b1111, seg=7'h7F, dp=1, FSM=IDLE, disp_bcd=0, disp_valid=0, last_bin=0, slot counter=0, digit index=0.
- Conversion FSM, states IDLE, LOAD, SHIFT, DONE:
  - IDLE: go to LOAD when disp_valid=0 or cnt!=last_bin. The comparison uses cnt as seen that cycle.
  - LOAD: shift register := {16'h0, cnt}; last_bin := cnt; iteration count := 0.
  - SHIFT: runs exactly CNT_W cycles. Each cycle, add 3 to every BCD nibble >=5, then shift the whole register left by 1.
  - DONE: disp_bcd := BCD field; disp_valid := 1; return to IDLE.
  - Latency: cnt change visible in IDLE at cycle N; disp_bcd updates at the edge ending cycle N+CNT_W+2.
- Changes on cnt during LOAD/SHIFT/DONE are not tracked. On return to IDLE the current cnt is compared against last_bin, so the final settled value is always displayed. Intermediate values may be skipped.
- Multiplexer:
  - Slot counter runs 0..SLOT_CYC-1 then wraps.
  - At wrap, digit index increments mod 4 (0,1,2,3,0...).
  - While slot counter < GUARD_CYC, or disp_valid=0: an=4'b1111 and seg=7'h7F.
  - Otherwise an = ~(1<<index) and seg = decode(disp_bcd nibble[index]).
- Leading-zero blanking: digit k>0 is blanked (its anode stays high) when nibble k and all higher nibbles are 0. Digit 0 is never blanked, so value 0 shows "0".
- Decode (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibbles >9 are unreachable; decode to 7'h7F.
- Outputs seg/an are registered: one cycle after the slot counter/index that selects them.
- disp_bcd changes take effect at the next registered output update. A change mid-slot is allowed; no tearing beyond one slot.
- Reset asserted mid-conversion or mid-slot immediately forces the reset values. After release, the first conversion starts within 1 cycle of IDLE.

Decomposition:
- Shared package seg7_pkg:
  - FSM state typedef (IDLE, LOAD, SHIFT, DONE).
  - SEG_BLANK=7'h7F.
  - The ten digit segment constants.
  - Function nibble_to_seg.
- Sub-module bin2bcd_seq: the conversion FSM with handshake ports start/busy/done and bcd[15:0]. The top holds the change detector, multiplexer and output registers.

Test Plan:
- Reset then release, cnt=6'd0 (CLK_HZ=1600, DIGIT_HZ=100 → SLOT_CYC=16, GUARD_CYC=2) -> an=1111 during first 8 cycles. Thereafter only an[0] ever low, with seg=1000000.
- cnt=6'd63 -> disp_bcd=16'h0063 exactly 8 cycles after the change. an[0] shows 0110000 ("3"), an[1] shows 0000010 ("6"), an[2]/an[3] stay 1.
- cnt 6'd9 -> 6'd10 -> digits become "10". an[1] shows 1111001, an[0] shows 1000000, no leading blank on digit 1.
- cnt toggles 5→20→37 on consecutive cycles during SHIFT -> display settles to 16'h0037 within 2×(CNT_W+2)+1 cycles; no stuck intermediate value.
- Guard check over 8 slots -> an=1111 for first 2 cycles of every slot; never two anodes low simultaneously; dp always 1.
- rst pulsed low mid-SHIFT with cnt=42 -> outputs immediately blank. After release, disp_bcd=16'h0042 after CNT_W+2 cycles and "42" is displayed.
